// File: rtl/alu_pkg.sv
// Shared widths and types for the alu command queue and its FIFO.
package alu_pkg;

  localparam int W   = 4;
  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  typedef struct packed {
    alu_op_e      opcode;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_GAP   = 2'd2
  } issue_state_e;

  function automatic alu_cmd_t pack_cmd(input logic [OPW-1:0] opc,
                                        input logic [W-1:0]   a,
                                        input logic [W-1:0]   b);
    alu_cmd_t c;
    c.opcode = alu_op_e'(opc);
    c.op1    = a;
    c.op2    = b;
    return c;
  endfunction

endpackage

// File: rtl/alu_cmd_queue_if.sv
// Producer handshake plus the registered alu-facing command bus.
interface alu_cmd_queue_if;
  import alu_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_opcode;
  logic [W-1:0]   in_op1;
  logic [W-1:0]   in_op2;

  logic [OPW-1:0] OPCODE;
  logic [W-1:0]   OP1;
  logic [W-1:0]   OP2;
  logic           issue_valid;

  modport master (
    output in_valid, in_opcode, in_op1, in_op2,
    input  in_ready, OPCODE, OP1, OP2, issue_valid
  );

  modport slave (
    input  in_valid, in_opcode, in_op1, in_op2,
    output in_ready, OPCODE, OP1, OP2, issue_valid
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of alu commands; flush empties it and takes priority over push/pop.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  alu_cmd_t               wr_data,
  output alu_cmd_t               rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  alu_cmd_t      mem_q [DEPTH];
  alu_cmd_t      mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Payload storage carries no reset; only occupied slots are ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_cmd_queue.sv
// Issue stage in front of the alu: buffers commands and presents them on registered
// OPCODE/OP1/OP2 with a minimum spacing of ISSUE_GAP cycles between issues.
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ISSUE_GAP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_cmd_queue_if.slave         bus,
  input  logic                   flush,
  input  logic                   hold,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(ISSUE_GAP - 1);

  alu_cmd_t      in_cmd, head;
  alu_cmd_t      out_q, out_d;
  issue_state_e  state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          issue_valid_q, issue_valid_d;
  logic          overflow_q, overflow_d;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, count_nx;
  logic          push, fire;

  assign in_cmd       = pack_cmd(bus.in_opcode, bus.in_op1, bus.in_op2);
  assign bus.in_ready = !rst && !fifo_full;
  assign push         = bus.in_valid && bus.in_ready;
  assign fire         = !flush && (state_q != ST_GAP) && !fifo_empty && !hold;

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (fire),
    .flush   (flush),
    .wr_data (in_cmd),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    out_d         = out_q;
    issue_valid_d = 1'b0;
    gap_d         = (gap_q != '0) ? gap_q - GW'(1) : '0;
    overflow_d    = overflow_q | (bus.in_valid && !bus.in_ready);
    count_nx      = '0;
    if (flush) begin
      gap_d = '0;
    end else begin
      count_nx = fifo_count + CW'(push) - CW'(fire);
      if (fire) begin
        out_d         = head;
        issue_valid_d = 1'b1;
        gap_d         = GAP_LOAD;
      end
    end
    // State mirrors the post-edge gap and occupancy so it is valid the cycle it is read.
    if (gap_d != '0) begin
      state_d = ST_GAP;
    end else if (count_nx == '0) begin
      state_d = ST_IDLE;
    end else begin
      state_d = ST_ARMED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      gap_q         <= '0;
      out_q         <= '0;
      issue_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      out_q         <= out_d;
      issue_valid_q <= issue_valid_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.OPCODE      = out_q.opcode;
  assign bus.OP1         = out_q.op1;
  assign bus.OP2         = out_q.op2;
  assign bus.issue_valid = issue_valid_q;
  assign count           = fifo_count;
  assign overflow        = overflow_q;

endmodule
